// File: rtl/avalon_ahb_lite_bridge_if.sv
// Signal bundle for the Avalon-MM slave to AHB-Lite master bridge.
// The slave modport is the bridge's own view (Avalon slave, AHB master);
// the master modport is the surrounding system: Avalon initiator plus AHB slave.
interface avalon_ahb_lite_bridge_if #(
    parameter int unsigned HADDR_WIDTH = 32,
    parameter int unsigned HDATA_WIDTH = 32
);
    // Avalon-MM side
    logic [HADDR_WIDTH-1:0]   avs_address;
    logic                     avs_read;
    logic                     avs_write;
    logic [HDATA_WIDTH/8-1:0] avs_byteenable;
    logic [HDATA_WIDTH-1:0]   avs_writedata;
    logic                     avs_waitrequest;
    logic [HDATA_WIDTH-1:0]   avs_readdata;
    logic                     avs_readdatavalid;
    logic [1:0]               avs_response;

    // AHB-Lite side
    logic [HADDR_WIDTH-1:0]   HADDR;
    logic [1:0]               HTRANS;
    logic [2:0]               HSIZE;
    logic [2:0]               HBURST;
    logic                     HWRITE;
    logic [3:0]               HPROT;
    logic                     HMASTLOCK;
    logic [HDATA_WIDTH-1:0]   HWDATA;
    logic [HDATA_WIDTH-1:0]   HRDATA;
    logic                     HREADY;
    logic                     HRESP;

    logic                     bus_error;

    modport slave (
        input  avs_address, avs_read, avs_write, avs_byteenable, avs_writedata,
        output avs_waitrequest, avs_readdata, avs_readdatavalid, avs_response,
        output HADDR, HTRANS, HSIZE, HBURST, HWRITE, HPROT, HMASTLOCK, HWDATA,
        input  HRDATA, HREADY, HRESP,
        output bus_error
    );

    modport master (
        output avs_address, avs_read, avs_write, avs_byteenable, avs_writedata,
        input  avs_waitrequest, avs_readdata, avs_readdatavalid, avs_response,
        input  HADDR, HTRANS, HSIZE, HBURST, HWRITE, HPROT, HMASTLOCK, HWDATA,
        output HRDATA, HREADY, HRESP,
        input  bus_error
    );
endinterface

// File: rtl/avalon_ahb_lite_bridge.sv
// Avalon-MM slave to AHB-Lite master bridge. Non-pipelined, one outstanding
// transfer. Writes are posted; reads return data through readdatavalid.
// Byteenable patterns AHB cannot express are issued as a word read or as a
// sequence of byte writes in ascending lane order.
module avalon_ahb_lite_bridge #(
    parameter int unsigned HADDR_WIDTH = 32,
    parameter int unsigned HDATA_WIDTH = 32   // only 32 is supported
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    avalon_ahb_lite_bridge_if.slave io_bus
);
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] RESP_OKAY     = 2'b00;
    localparam logic [1:0] RESP_SLVERR   = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_e;

    state_e                 r_state;
    state_e                 w_state_next;

    logic [HADDR_WIDTH-1:0] r_haddr;
    logic [2:0]             r_hsize;
    logic                   r_hwrite;
    logic [3:0]             r_lanes;      // byte lanes still to be written
    logic [HDATA_WIDTH-1:0] r_wdata;
    logic [HDATA_WIDTH-1:0] r_rdata;
    logic [1:0]             r_resp;
    logic                   r_bus_error;

    logic                   w_req;
    logic                   w_is_read;
    logic [2:0]             w_dec_size;
    logic [1:0]             w_dec_off;
    logic [3:0]             w_dec_lanes;
    logic                   w_dec_skip;
    logic                   w_done_ok;
    logic                   w_done_err;
    logic                   w_unused_addr_lo;

    // Index of the lowest set lane in a byteenable mask.
    function automatic logic [1:0] low_lane(input logic [3:0] mask);
        if (mask[0]) begin
            return 2'd0;
        end else if (mask[1]) begin
            return 2'd1;
        end else if (mask[2]) begin
            return 2'd2;
        end
        return 2'd3;
    endfunction

    assign w_req      = (r_state == S_IDLE) && (io_bus.avs_read || io_bus.avs_write);
    assign w_is_read  = io_bus.avs_read;  // read wins when both are asserted
    assign w_done_ok  = (r_state == S_DATA) && io_bus.HREADY && !io_bus.HRESP;
    assign w_done_err = (r_state == S_DATA) && io_bus.HREADY && io_bus.HRESP;

    // The address is always rebuilt from the byteenable decode.
    assign w_unused_addr_lo = ^io_bus.avs_address[1:0];

    // Map the incoming byteenable onto HSIZE, address offset and leftover lanes.
    always_comb begin
        w_dec_size  = 3'd2;
        w_dec_off   = 2'd0;
        w_dec_lanes = 4'd0;
        w_dec_skip  = 1'b0;
        case (io_bus.avs_byteenable)
            4'b0001: begin w_dec_size = 3'd0; w_dec_off = 2'd0; end
            4'b0010: begin w_dec_size = 3'd0; w_dec_off = 2'd1; end
            4'b0100: begin w_dec_size = 3'd0; w_dec_off = 2'd2; end
            4'b1000: begin w_dec_size = 3'd0; w_dec_off = 2'd3; end
            4'b0011: begin w_dec_size = 3'd1; w_dec_off = 2'd0; end
            4'b1100: begin w_dec_size = 3'd1; w_dec_off = 2'd2; end
            4'b1111: begin w_dec_size = 3'd2; w_dec_off = 2'd0; end
            default: begin
                // Reads fall back to a whole word; writes split into bytes.
                if (!w_is_read) begin
                    if (io_bus.avs_byteenable == 4'b0000) begin
                        w_dec_skip = 1'b1;
                    end else begin
                        w_dec_size  = 3'd0;
                        w_dec_off   = low_lane(io_bus.avs_byteenable);
                        w_dec_lanes = io_bus.avs_byteenable & (io_bus.avs_byteenable - 4'd1);
                    end
                end
            end
        endcase
    end

    // State register.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req && !w_dec_skip) begin
                    w_state_next = S_ADDR;
                end
            end
            S_ADDR: begin
                if (io_bus.HREADY) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_done_err) begin
                    w_state_next = r_hwrite ? S_IDLE : S_RESP;
                end else if (w_done_ok) begin
                    if (!r_hwrite) begin
                        w_state_next = S_RESP;
                    end else if (r_lanes != 4'd0) begin
                        w_state_next = S_ADDR;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            S_RESP: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Command capture, byte-lane stepping and read/error result registers.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_haddr     <= '0;
            r_hsize     <= 3'd0;
            r_hwrite    <= 1'b0;
            r_lanes     <= 4'd0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_resp      <= RESP_OKAY;
            r_bus_error <= 1'b0;
        end else begin
            r_bus_error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_haddr  <= {io_bus.avs_address[HADDR_WIDTH-1:2], w_dec_off};
                        r_hsize  <= w_dec_size;
                        r_hwrite <= !w_is_read;
                        r_lanes  <= w_dec_lanes;
                        r_wdata  <= io_bus.avs_writedata;
                    end
                end
                S_DATA: begin
                    if (w_done_err) begin
                        // An error abandons any byte lanes not yet written.
                        r_lanes     <= 4'd0;
                        r_bus_error <= 1'b1;
                        if (!r_hwrite) begin
                            r_resp <= RESP_SLVERR;
                        end
                    end else if (w_done_ok) begin
                        if (!r_hwrite) begin
                            r_rdata <= io_bus.HRDATA;
                            r_resp  <= RESP_OKAY;
                        end else if (r_lanes != 4'd0) begin
                            r_haddr[1:0] <= low_lane(r_lanes);
                            r_lanes      <= r_lanes & (r_lanes - 4'd1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign io_bus.avs_waitrequest   = HRESET || (r_state != S_IDLE);
    assign io_bus.avs_readdata      = r_rdata;
    assign io_bus.avs_readdatavalid = (r_state == S_RESP);
    assign io_bus.avs_response      = r_resp;

    assign io_bus.HADDR     = r_haddr;
    assign io_bus.HTRANS    = (r_state == S_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign io_bus.HSIZE     = r_hsize;
    assign io_bus.HBURST    = 3'b000;
    assign io_bus.HWRITE    = r_hwrite;
    assign io_bus.HPROT     = 4'b0011;
    assign io_bus.HMASTLOCK = 1'b0;
    assign io_bus.HWDATA    = r_wdata;
    assign io_bus.bus_error = r_bus_error;
endmodule

// File: tb/tb_avalon_ahb_lite_bridge.sv
// Directed testbench for avalon_ahb_lite_bridge. Inputs change on the falling
// edge and outputs are sampled there too, half a cycle from the active edge.
module tb_avalon_ahb_lite_bridge;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    avalon_ahb_lite_bridge_if #(.HADDR_WIDTH(32), .HDATA_WIDTH(32)) bif ();

    avalon_ahb_lite_bridge #(.HADDR_WIDTH(32), .HDATA_WIDTH(32)) dut (
        .HCLK   (clk),
        .HRESET (rst),
        .io_bus (bif)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bif.avs_read  = 1'b0;
        bif.avs_write = 1'b0;
        bif.HREADY    = 1'b1;
        bif.HRESP     = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bif.avs_address    = 32'h0;
        bif.avs_byteenable = 4'h0;
        bif.avs_writedata  = 32'h0;
        bif.HRDATA         = 32'h0;
        rst = 1'b1;
        step();
        step();
        total++; if (bif.avs_waitrequest !== 1'b1) begin bad++; $display("FAIL rst_waitreq: got %b want 1", bif.avs_waitrequest); end
        total++; if (bif.HTRANS !== 2'b00) begin bad++; $display("FAIL rst_htrans: got %b want 00", bif.HTRANS); end
        total++; if (bif.avs_readdatavalid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", bif.avs_readdatavalid); end
        total++; if (bif.avs_response !== 2'b00) begin bad++; $display("FAIL rst_resp: got %b want 00", bif.avs_response); end
        total++; if (bif.bus_error !== 1'b0) begin bad++; $display("FAIL rst_berr: got %b want 0", bif.bus_error); end
        total++; if (bif.HADDR !== 32'h0) begin bad++; $display("FAIL rst_haddr: got %h want 0", bif.HADDR); end
        total++; if (bif.HWDATA !== 32'h0) begin bad++; $display("FAIL rst_hwdata: got %h want 0", bif.HWDATA); end
        total++; if (bif.avs_readdata !== 32'h0) begin bad++; $display("FAIL rst_rdata: got %h want 0", bif.avs_readdata); end
        total++; if (bif.HBURST !== 3'b000) begin bad++; $display("FAIL rst_hburst: got %b want 000", bif.HBURST); end
        total++; if (bif.HPROT !== 4'b0011) begin bad++; $display("FAIL rst_hprot: got %b want 0011", bif.HPROT); end
        total++; if (bif.HMASTLOCK !== 1'b0) begin bad++; $display("FAIL rst_hmastlock: got %b want 0", bif.HMASTLOCK); end
        rst = 1'b0;
        #1;
        total++; if (bif.avs_waitrequest !== 1'b0) begin bad++; $display("FAIL rst_release_waitreq: got %b want 0", bif.avs_waitrequest); end
    endtask

    task automatic test_read_basic();
        bif.avs_address    = 32'h0000_0100;
        bif.avs_byteenable = 4'b1111;
        bif.HRDATA         = 32'hDEAD_BEEF;
        bif.avs_read       = 1'b1;
        step();  // T1
        bif.avs_read = 1'b0;
        total++; if (bif.HTRANS !== 2'b10) begin bad++; $display("FAIL rd_htrans_t1: got %b want 10", bif.HTRANS); end
        total++; if (bif.HADDR !== 32'h0000_0100) begin bad++; $display("FAIL rd_haddr: got %h want 00000100", bif.HADDR); end
        total++; if (bif.HSIZE !== 3'd2) begin bad++; $display("FAIL rd_hsize: got %0d want 2", bif.HSIZE); end
        total++; if (bif.HWRITE !== 1'b0) begin bad++; $display("FAIL rd_hwrite: got %b want 0", bif.HWRITE); end
        total++; if (bif.avs_waitrequest !== 1'b1) begin bad++; $display("FAIL rd_waitreq_t1: got %b want 1", bif.avs_waitrequest); end
        step();  // T2
        total++; if (bif.HTRANS !== 2'b00) begin bad++; $display("FAIL rd_htrans_t2: got %b want 00", bif.HTRANS); end
        total++; if (bif.avs_readdatavalid !== 1'b0) begin bad++; $display("FAIL rd_valid_t2: got %b want 0", bif.avs_readdatavalid); end
        step();  // T3
        total++; if (bif.avs_readdatavalid !== 1'b1) begin bad++; $display("FAIL rd_valid_t3: got %b want 1", bif.avs_readdatavalid); end
        total++; if (bif.avs_readdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_data: got %h want deadbeef", bif.avs_readdata); end
        total++; if (bif.avs_response !== 2'b00) begin bad++; $display("FAIL rd_resp: got %b want 00", bif.avs_response); end
        step();  // T4
        total++; if (bif.avs_waitrequest !== 1'b0) begin bad++; $display("FAIL rd_waitreq_t4: got %b want 0", bif.avs_waitrequest); end
        total++; if (bif.avs_readdatavalid !== 1'b0) begin bad++; $display("FAIL rd_valid_t4: got %b want 0", bif.avs_readdatavalid); end
    endtask

    task automatic test_write_half();
        bif.avs_address    = 32'h0000_0204;
        bif.avs_byteenable = 4'b1100;
        bif.avs_writedata  = 32'h1122_3344;
        bif.avs_write      = 1'b1;
        step();  // T1
        bif.avs_write = 1'b0;
        total++; if (bif.HTRANS !== 2'b10) begin bad++; $display("FAIL wh_htrans: got %b want 10", bif.HTRANS); end
        total++; if (bif.HADDR !== 32'h0000_0206) begin bad++; $display("FAIL wh_haddr: got %h want 00000206", bif.HADDR); end
        total++; if (bif.HSIZE !== 3'd1) begin bad++; $display("FAIL wh_hsize: got %0d want 1", bif.HSIZE); end
        total++; if (bif.HWRITE !== 1'b1) begin bad++; $display("FAIL wh_hwrite: got %b want 1", bif.HWRITE); end
        step();  // T2
        total++; if (bif.HWDATA !== 32'h1122_3344) begin bad++; $display("FAIL wh_hwdata: got %h want 11223344", bif.HWDATA); end
        total++; if (bif.HTRANS !== 2'b00) begin bad++; $display("FAIL wh_htrans_t2: got %b want 00", bif.HTRANS); end
        total++; if (bif.avs_waitrequest !== 1'b1) begin bad++; $display("FAIL wh_waitreq_t2: got %b want 1", bif.avs_waitrequest); end
        step();  // T3
        total++; if (bif.avs_waitrequest !== 1'b0) begin bad++; $display("FAIL wh_waitreq_t3: got %b want 0", bif.avs_waitrequest); end
    endtask

    task automatic test_write_split();
        logic [31:0] addrs [4];
        int          n    = 0;
        int          fall = 0;
        bif.avs_address    = 32'h0000_0040;
        bif.avs_byteenable = 4'b1010;
        bif.avs_writedata  = 32'hA5A5_5A5A;
        bif.avs_write      = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c == 1) bif.avs_write = 1'b0;
            if (bif.HTRANS === 2'b10) begin
                if (n < 4) addrs[n] = bif.HADDR;
                n++;
                total++; if (bif.HSIZE !== 3'd0) begin bad++; $display("FAIL ws_hsize: got %0d want 0", bif.HSIZE); end
            end
            if (c == 2) begin
                total++; if (bif.HWDATA !== 32'hA5A5_5A5A) begin bad++; $display("FAIL ws_hwdata: got %h want a5a55a5a", bif.HWDATA); end
            end
            if (fall == 0 && bif.avs_waitrequest === 1'b0) fall = c;
        end
        total++; if (n !== 2) begin bad++; $display("FAIL ws_count: got %0d want 2", n); end
        if (n >= 2) begin
            total++; if (addrs[0] !== 32'h41) begin bad++; $display("FAIL ws_addr0: got %h want 00000041", addrs[0]); end
            total++; if (addrs[1] !== 32'h43) begin bad++; $display("FAIL ws_addr1: got %h want 00000043", addrs[1]); end
        end
        total++; if (fall !== 5) begin bad++; $display("FAIL ws_latency: got %0d want 5", fall); end
    endtask

    task automatic test_read_wait();
        int vcyc = 0;
        bif.avs_address    = 32'h0000_0104;
        bif.avs_byteenable = 4'b1111;
        bif.HRDATA         = 32'hCAFE_F00D;
        bif.avs_read       = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (c == 1) bif.avs_read = 1'b0;
            if (c >= 2 && c <= 4) begin
                total++; if (bif.HTRANS !== 2'b00) begin bad++; $display("FAIL rw_htrans_c%0d: got %b want 00", c, bif.HTRANS); end
            end
            if (vcyc == 0 && bif.avs_readdatavalid === 1'b1) begin
                vcyc = c;
                total++; if (bif.avs_readdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL rw_data: got %h want cafef00d", bif.avs_readdata); end
            end
            bif.HREADY = (c != 2 && c != 3);
        end
        bif.HREADY = 1'b1;
        total++; if (vcyc !== 5) begin bad++; $display("FAIL rw_latency: got %0d want 5", vcyc); end
    endtask

    task automatic test_read_error();
        int vcyc = 0;
        int ecyc = 0;
        int epul = 0;
        bif.avs_address    = 32'h0000_0108;
        bif.avs_byteenable = 4'b1111;
        bif.avs_read       = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c == 1) bif.avs_read = 1'b0;
            if (bif.bus_error === 1'b1) begin epul++; if (ecyc == 0) ecyc = c; end
            if (vcyc == 0 && bif.avs_readdatavalid === 1'b1) begin
                vcyc = c;
                total++; if (bif.avs_response !== 2'b10) begin bad++; $display("FAIL re_resp: got %b want 10", bif.avs_response); end
            end
            bif.HRESP  = (c == 2 || c == 3);
            bif.HREADY = (c != 2);
        end
        total++; if (vcyc !== 4) begin bad++; $display("FAIL re_valid_cycle: got %0d want 4", vcyc); end
        total++; if (ecyc !== 4) begin bad++; $display("FAIL re_berr_cycle: got %0d want 4", ecyc); end
        total++; if (epul !== 1) begin bad++; $display("FAIL re_berr_width: got %0d want 1", epul); end
        // Bridge must accept a fresh command afterwards.
        bif.avs_address    = 32'h0000_0008;
        bif.avs_byteenable = 4'b0001;
        bif.HRDATA         = 32'h0000_0055;
        bif.avs_read       = 1'b1;
        step();
        bif.avs_read = 1'b0;
        total++; if (bif.HTRANS !== 2'b10 || bif.HADDR !== 32'h8 || bif.HSIZE !== 3'd0) begin
            bad++; $display("FAIL re_next_cmd: got trans=%b addr=%h size=%0d want 10/00000008/0", bif.HTRANS, bif.HADDR, bif.HSIZE);
        end
        step();
        step();
        total++; if (bif.avs_readdatavalid !== 1'b1 || bif.avs_readdata !== 32'h55 || bif.avs_response !== 2'b00) begin
            bad++; $display("FAIL re_next_data: got v=%b d=%h r=%b want 1/00000055/00", bif.avs_readdatavalid, bif.avs_readdata, bif.avs_response);
        end
        step();
    endtask

    task automatic test_write_error();
        int          n    = 0;
        logic [31:0] a0   = 32'hFFFF_FFFF;
        int          ecyc = 0;
        int          vcnt = 0;
        bif.avs_address    = 32'h0000_0080;
        bif.avs_byteenable = 4'b1011;
        bif.avs_writedata  = 32'h0102_0304;
        bif.avs_write      = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (c == 1) bif.avs_write = 1'b0;
            if (bif.HTRANS === 2'b10) begin if (n == 0) a0 = bif.HADDR; n++; end
            if (ecyc == 0 && bif.bus_error === 1'b1) ecyc = c;
            if (bif.avs_readdatavalid === 1'b1) vcnt++;
            bif.HRESP  = (c == 2 || c == 3);
            bif.HREADY = (c != 2);
        end
        total++; if (n !== 1) begin bad++; $display("FAIL we_count: got %0d want 1", n); end
        total++; if (a0 !== 32'h80) begin bad++; $display("FAIL we_addr: got %h want 00000080", a0); end
        total++; if (ecyc !== 4) begin bad++; $display("FAIL we_berr_cycle: got %0d want 4", ecyc); end
        total++; if (vcnt !== 0) begin bad++; $display("FAIL we_valid: got %0d want 0", vcnt); end
    endtask

    task automatic test_reset_midway();
        int vcnt = 0;
        int ecnt = 0;
        bif.avs_address    = 32'h0000_010C;
        bif.avs_byteenable = 4'b1111;
        bif.avs_read       = 1'b1;
        step();  // ADDR
        bif.avs_read = 1'b0;
        step();  // DATA, slave stalls
        bif.HREADY = 1'b0;
        rst        = 1'b1;
        #1;
        total++; if (bif.avs_waitrequest !== 1'b1) begin bad++; $display("FAIL rm_waitreq: got %b want 1", bif.avs_waitrequest); end
        step();
        total++; if (bif.HTRANS !== 2'b00) begin bad++; $display("FAIL rm_htrans: got %b want 00", bif.HTRANS); end
        rst        = 1'b0;
        bif.HREADY = 1'b1;
        #1;
        total++; if (bif.avs_waitrequest !== 1'b0) begin bad++; $display("FAIL rm_idle: got %b want 0", bif.avs_waitrequest); end
        for (int c = 0; c < 5; c++) begin
            step();
            if (bif.avs_readdatavalid === 1'b1) vcnt++;
            if (bif.bus_error === 1'b1) ecnt++;
        end
        total++; if (vcnt !== 0 || ecnt !== 0) begin bad++; $display("FAIL rm_no_pulse: got valid=%0d berr=%0d want 0/0", vcnt, ecnt); end
        bif.avs_address = 32'h0000_0200;
        bif.HRDATA      = 32'h0BAD_F00D;
        bif.avs_read    = 1'b1;
        step();
        bif.avs_read = 1'b0;
        step();
        step();
        total++; if (bif.avs_readdatavalid !== 1'b1 || bif.avs_readdata !== 32'h0BAD_F00D) begin
            bad++; $display("FAIL rm_after: got v=%b d=%h want 1/0badf00d", bif.avs_readdatavalid, bif.avs_readdata);
        end
        step();
    endtask

    task automatic test_odd_patterns();
        // Write with no lanes: accepted, no transfer.
        bif.avs_address    = 32'h0000_0050;
        bif.avs_byteenable = 4'b0000;
        bif.avs_write      = 1'b1;
        step();
        bif.avs_write = 1'b0;
        total++; if (bif.avs_waitrequest !== 1'b0 || bif.HTRANS !== 2'b00) begin
            bad++; $display("FAIL be0_write: got wr=%b trans=%b want 0/00", bif.avs_waitrequest, bif.HTRANS);
        end
        // Read and write together with an irregular mask: word read at offset 0.
        bif.avs_address    = 32'h0000_0033;
        bif.avs_byteenable = 4'b0101;
        bif.HRDATA         = 32'h7777_1234;
        bif.avs_read       = 1'b1;
        bif.avs_write      = 1'b1;
        step();
        bif.avs_read  = 1'b0;
        bif.avs_write = 1'b0;
        total++; if (bif.HTRANS !== 2'b10 || bif.HADDR !== 32'h30 || bif.HSIZE !== 3'd2 || bif.HWRITE !== 1'b0) begin
            bad++; $display("FAIL odd_read: got trans=%b addr=%h size=%0d wr=%b want 10/00000030/2/0", bif.HTRANS, bif.HADDR, bif.HSIZE, bif.HWRITE);
        end
        step();
        step();
        total++; if (bif.avs_readdatavalid !== 1'b1 || bif.avs_readdata !== 32'h7777_1234) begin
            bad++; $display("FAIL odd_read_data: got v=%b d=%h want 1/77771234", bif.avs_readdatavalid, bif.avs_readdata);
        end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_read_basic();
        test_write_half();
        test_write_split();
        test_read_wait();
        test_read_error();
        test_write_error();
        test_reset_midway();
        test_odd_patterns();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
